ifetch: RTL and testbench

RV32I instruction fetch stage: holds the PC, issues one word read at a time to instruction memory, and presents each fetched instruction with its opcode field and PC to decode and immediate generation. Branch and jump redirects from execute re-steer the PC. Stale in-flight responses are discarded.

---
 rtl/ifetch_if.sv | 33 +++
 rtl/ifetch.sv | 135 +++++++++++++
 tb/tb_ifetch.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and decode handshake.
// Signal names keep the fetch stage's i_/o_ view; the master modport is the fetch stage itself.
interface ifetch_if;
    logic        o_imem_valid;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [6:0]  o_opcode;
    logic [31:0] o_pc;
    logic        o_fault;

    modport master (
        output o_imem_valid, o_imem_addr,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata,
        input  i_redirect, i_redirect_pc,
        output o_valid, o_inst, o_opcode, o_pc, o_fault,
        input  i_ready
    );

    modport slave (
        input  o_imem_valid, o_imem_addr,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata,
        output i_redirect, i_redirect_pc,
        input  o_valid, o_inst, o_opcode, o_pc, o_fault,
        output i_ready
    );
endinterface

// File: rtl/ifetch.sv
// RV32I fetch stage: one outstanding word read, registered output to decode, redirect with stale-response drain.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect targets in S_FAULT instead of truncating them.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      i_clk,
    input logic      i_rst,
    ifetch_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DRAIN
`ifdef IFETCH_ALIGN_CHECK_EN
        , S_FAULT
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        imem_req;
    logic        hs;
    logic        accept;
    logic        drain_next;
    logic [31:0] redir_pc;

    // Hold off the request while decode is stalled on a full output register.
    assign imem_req   = (state == S_REQ) && (!valid_q || bus.i_ready);
    assign hs         = imem_req && bus.i_imem_ready;
    assign accept     = valid_q && bus.i_ready;
    // A redirect must wait out a response that is (or is about to be) outstanding.
    assign drain_next = ((state == S_REQ) && hs) ||
                        (((state == S_RESP) || (state == S_DRAIN)) && !bus.i_imem_rvalid);

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic fault_pend;
    logic bad_target;

    assign bad_target  = |bus.i_redirect_pc[1:0];
    assign redir_pc    = bus.i_redirect_pc;
    assign bus.o_fault = fault_q;
`else
    assign redir_pc    = {bus.i_redirect_pc[31:2], 2'b00};
    assign bus.o_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
            fault_pend <= 1'b0;
`endif
        end else if (bus.i_redirect) begin
            valid_q <= 1'b0;
            pc      <= redir_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
            fault_pend <= bad_target;
`endif
            if (drain_next)
                state <= S_DRAIN;
`ifdef IFETCH_ALIGN_CHECK_EN
            else if (bad_target) begin
                state   <= S_FAULT;
                valid_q <= 1'b1;
                fault_q <= 1'b1;
                pc_q    <= bus.i_redirect_pc;
                inst_q  <= NOP;
            end
`endif
            else
                state <= S_REQ;
        end else begin
            if (accept)
                valid_q <= 1'b0;
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (hs)
                        state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.i_imem_rvalid) begin
                        inst_q  <= bus.i_imem_rdata;
                        pc_q    <= pc;
                        valid_q <= 1'b1;
                        pc      <= pc + 32'd4;
                        state   <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.i_imem_rvalid) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                        if (fault_pend) begin
                            state   <= S_FAULT;
                            valid_q <= 1'b1;
                            fault_q <= 1'b1;
                            pc_q    <= pc;
                            inst_q  <= NOP;
                        end else begin
                            state <= S_REQ;
                        end
`else
                        state <= S_REQ;
`endif
                    end
                end
`ifdef IFETCH_ALIGN_CHECK_EN
                // Fault outputs persist until a redirect, even if decode consumes them.
                S_FAULT: valid_q <= 1'b1;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_imem_valid = imem_req;
    assign bus.o_imem_addr  = pc;
    assign bus.o_valid      = valid_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_opcode     = inst_q[6:0];
    assign bus.o_pc         = pc_q;
endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: latency-configurable memory model, scoreboard of fetched words, directed + random phases.
module tb_ifetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   lat = 1;
    int   mem_cnt = 0;
    logic mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_next = RST_PC;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_inst = '0;
    int   acc_cnt = 0;
    exp_t sb[$];

    ifetch_if bus();

    ifetch #(.RESET_PC(RST_PC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + ((a - 32'h100) << 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ovalid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk(tag, bus.o_valid, 1);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_imem_valid && n < 20) begin
            chk({tag, "_no_valid"}, bus.o_valid, 0);
            n++;
            @(negedge clk);
        end
        chk(tag, bus.o_imem_valid, 1);
    endtask

    // Memory responder: one response per accepted request, lat cycles after the handshake.
    initial begin
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_imem_rvalid = 1'b0;
            if (rst) begin
                mem_pend = 1'b0;
            end else if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.i_imem_rvalid = 1'b1;
                    bus.i_imem_rdata  = mem_word(mem_addr);
                    mem_pend = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.o_valid && bus.i_ready && !bus.o_fault) begin
                if (sb.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                end else begin
                    e = sb.pop_front();
                    acc_cnt++;
                    chk("acc_pc", bus.o_pc, e.pc);
                    chk("acc_inst", bus.o_inst, e.inst);
                    chk("acc_opcode", {25'd0, bus.o_opcode}, {25'd0, e.inst[6:0]});
                end
            end
            if (stall_prev && bus.o_valid) begin
                chk("hold_pc", bus.o_pc, prev_pc);
                chk("hold_inst", bus.o_inst, prev_inst);
            end
            stall_prev = bus.o_valid && !bus.i_ready && !bus.i_redirect;
            prev_pc    = bus.o_pc;
            prev_inst  = bus.o_inst;
            if (bus.o_imem_valid && bus.i_imem_ready) begin
                chk("one_outstanding", {31'd0, mem_pend || bus.i_imem_rvalid}, 0);
                chk("req_addr", bus.o_imem_addr, exp_next);
                mem_pend = 1'b1;
                mem_cnt  = lat;
                mem_addr = bus.o_imem_addr;
                e.pc     = bus.o_imem_addr;
                e.inst   = mem_word(bus.o_imem_addr);
                sb.push_back(e);
                exp_next = bus.o_imem_addr + 32'd4;
            end
            if (bus.i_redirect) begin
                sb.delete();
                exp_next = {bus.i_redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_imem_ready  = 1'b1;
        bus.i_ready       = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_valid", bus.o_imem_valid, 0);
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_fault", bus.o_fault, 0);
        chk("rst_inst", bus.o_inst, 0);
        chk("rst_opcode", bus.o_opcode, 0);
        chk("rst_pc", bus.o_pc, 0);
        chk("rst_addr", bus.o_imem_addr, RST_PC);

        // Reset release: cycle 0 idle, cycle 1 request, cycle 3 instruction out.
        step(); rst = 1'b0;
        @(negedge clk); chk("c0_idle", bus.o_imem_valid, 0);
        step(); @(negedge clk);
        chk("c1_req", bus.o_imem_valid, 1);
        chk("c1_addr", bus.o_imem_addr, 32'h100);
        step(); @(negedge clk);
        chk("c2_no_valid", bus.o_valid, 0);
        step(); @(negedge clk);
        chk("c3_valid", bus.o_valid, 1);
        chk("c3_opcode", bus.o_opcode, 7'h13);
        chk("c3_pc", bus.o_pc, 32'h100);
        chk("c3_inst", bus.o_inst, 32'h0050_0093);
        chk("c3_next_addr", bus.o_imem_addr, 32'h104);
        chk("c3_next_req", bus.o_imem_valid, 1);

        // Decode stall for 5 cycles.
        step(); bus.i_ready = 1'b0;
        wait_ovalid("stall_fill");
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_req", bus.o_imem_valid, 0);
            chk("stall_pc", bus.o_pc, 32'h104);
            chk("stall_inst", bus.o_inst, mem_word(32'h104));
            if (i < 4) @(negedge clk);
        end
        step(); bus.i_ready = 1'b1; lat = 3;
        @(negedge clk);
        chk("release_req", bus.o_imem_valid, 1);
        chk("release_addr", bus.o_imem_addr, 32'h108);

        // Redirect one cycle after handshake with a slow response.
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h200;
        step(); bus.i_redirect = 1'b0; lat = 1;
        wait_req("drain_req");
        chk("drain_addr", bus.o_imem_addr, 32'h200);
        chk("drain_o_valid", bus.o_valid, 0);

        // Redirect in the same cycle as rvalid.
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h300;
        step(); bus.i_redirect = 1'b0;
        @(negedge clk);
        chk("rv_redir_req", bus.o_imem_valid, 1);
        chk("rv_redir_addr", bus.o_imem_addr, 32'h300);
        chk("rv_redir_no_valid", bus.o_valid, 0);

        // Redirect while decode holds a stalled instruction.
        step(); bus.i_ready = 1'b0;
        wait_ovalid("stall2_fill");
        chk("stall2_pc", bus.o_pc, 32'h300);
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h500;
        @(negedge clk); chk("redir_stall_hold", bus.o_valid, 1);
        step(); bus.i_redirect = 1'b0; bus.i_ready = 1'b1;
        @(negedge clk); chk("redir_stall_clr", bus.o_valid, 0);
        step();
        wait_ovalid("post_redir");
        chk("post_redir_pc", bus.o_pc, 32'h500);

        // Misaligned redirect target.
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h202;
        step(); bus.i_redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.o_fault && n < 20) begin
                n++;
                @(negedge clk);
            end
        end
        chk("fault_set", bus.o_fault, 1);
        chk("fault_pc", bus.o_pc, 32'h202);
        chk("fault_inst", bus.o_inst, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            chk("fault_no_req", bus.o_imem_valid, 0);
            chk("fault_valid", bus.o_valid, 1);
            chk("fault_hold", bus.o_fault, 1);
            @(negedge clk);
        end
        step(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h400;
        step(); bus.i_redirect = 1'b0;
        @(negedge clk);
        chk("fault_clr", bus.o_fault, 0);
        chk("fault_exit_req", bus.o_imem_valid, 1);
        chk("fault_exit_addr", bus.o_imem_addr, 32'h400);
`else
        wait_req("misalign_req");
        chk("misalign_addr", bus.o_imem_addr, 32'h200);
        chk("misalign_nofault", bus.o_fault, 0);
`endif

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            step();
            bus.i_ready       = ($urandom_range(0, 3) != 0);
            bus.i_imem_ready  = ($urandom_range(0, 2) != 0);
            lat               = int'($urandom_range(1, 3));
            bus.i_redirect    = ($urandom_range(0, 15) == 0);
            bus.i_redirect_pc = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
        end
        step();
        bus.i_redirect   = 1'b0;
        bus.i_ready      = 1'b1;
        bus.i_imem_ready = 1'b1;
        repeat (10) step();
        chk("random_progress", {31'd0, acc_cnt >= 30}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
